// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane decode helper.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables for a legal (already error-checked) transfer.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << lo;
      HSIZE_HALF: byte_lanes = lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_byte_ram.sv
// Word-organised SRAM with per-byte write enables; synchronous write, asynchronous read.
module ahblite_byte_ram #(
  parameter int AW = 8
) (
  input  logic          HCLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahblite_sram_responder.sv
// AHB-Lite slave backed by an on-chip SRAM: address-phase capture, error decode,
// configurable wait states and the two-cycle ERROR response.
module ahblite_sram_responder
  import ahblite_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_STATES = 0,
  parameter int WIN_BITS    = 16
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  state_t              state;
  logic [2:0]          cnt;
  logic [WIN_BITS-1:0] win_addr;
  logic                accept;
  logic                addr_err;
  logic [AW+1:0]       addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [31:0]         ram_rdata;
  logic                unused_bits;

  assign win_addr    = HADDR[WIN_BITS-1:0];
  assign unused_bits = ^{HADDR[31:WIN_BITS], HTRANS[0]};

  // Only states whose data phase completes this cycle may take a new address phase.
  assign accept = HSEL && HREADY && HTRANS[1] &&
                  (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > HSIZE_WORD) addr_err = 1'b1;
    if (HSIZE == HSIZE_HALF && win_addr[0]) addr_err = 1'b1;
    if (HSIZE == HSIZE_WORD && win_addr[1:0] != 2'b00) addr_err = 1'b1;
    if ((win_addr >> (AW + 2)) != '0) addr_err = 1'b1;
  end

  // Errors are resolved at acceptance, so only the in-array address bits are kept.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_q  <= win_addr[AW+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          if (accept && addr_err) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else if (accept && WAIT_STATES > 0) begin
            state     <= ST_WAIT;
            cnt       <= 3'(WAIT_STATES);
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_OKAY;
          end else if (accept) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign ram_we = (state == ST_DATA) && write_q;
  assign ram_be = byte_lanes(size_q, addr_q[1:0]);
  assign HRDATA = (state == ST_DATA && !write_q) ? ram_rdata : 32'h0;

  ahblite_byte_ram #(.AW(AW)) u_ram (
    .HCLK  (HCLK),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr_q[AW+1:2]),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ahblite_sram_responder.sv
// Directed bench: one responder with zero wait states and one with three, on a shared bus.
module tb_ahblite_sram_responder;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n, hsel0, hsel3, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        rdy0, resp0, rdy3, resp3;
  logic [31:0] rdata0, rdata3;
  logic [31:0] rd;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ahblite_sram_responder #(.AW(8), .WAIT_STATES(0), .WIN_BITS(16)) dut0 (
    .HCLK(clk), .HRESETN(rst0_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy0), .HWDATA(hwdata),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahblite_sram_responder #(.AW(8), .WAIT_STATES(3), .WIN_BITS(16)) dut3 (
    .HCLK(clk), .HRESETN(rst3_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy3), .HWDATA(hwdata),
    .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic w, input logic [2:0] sz, input logic [31:0] a);
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
  endtask

  // Single non-pipelined transfer on the zero-wait responder.
  task automatic xfer0(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdo);
    hsel0 = 1'b1;
    addr_ph(w, sz, a);
    step();
    htrans = 2'b00;
    hwdata = wd;
    @(negedge clk);
    chk("ws0_okay", 32'({rdy0, resp0}), 32'b10);
    rdo = rdata0;
    step();
  endtask

  // Error transfer (issued as a write of all-ones) on the zero-wait responder.
  task automatic err0(input string tag, input logic [2:0] sz, input logic [31:0] a);
    hsel0 = 1'b1;
    addr_ph(1'b1, sz, a);
    step();
    htrans = 2'b00;
    hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({tag, "_c1"}, 32'({rdy0, resp0}), 32'b01);
    step();
    @(negedge clk);
    chk({tag, "_c2"}, 32'({rdy0, resp0}), 32'b11);
    step();
    @(negedge clk);
    chk({tag, "_after"}, 32'({rdy0, resp0}), 32'b10);
  endtask

  task automatic noop0(input string tag, input logic sel, input logic [1:0] tr);
    hsel0  = sel;
    htrans = tr;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h0;
    step();
    hwdata = 32'hFFFF_FFFF;
    htrans = 2'b00;
    @(negedge clk);
    chk(tag, 32'({rdy0, resp0}), 32'b10);
    step();
  endtask

  // Transfer on the three-wait responder; checks the wait length is exactly three.
  task automatic xfer3(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdo);
    int n;
    hsel3 = 1'b1;
    addr_ph(w, 3'b010, a);
    step();
    htrans = 2'b00;
    hwdata = wd;
    n = 0;
    @(negedge clk);
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ws3_wait_len", 32'(n), 32'd3);
    rdo = rdata3;
    step();
  endtask

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0;
    htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000; haddr = 32'h0; hwdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ws0", {rdy0, resp0, 30'd0} | 32'(rdata0 != 0), 32'h8000_0000);
    chk("rst_ws3", {rdy3, resp3, 30'd0} | 32'(rdata3 != 0), 32'h8000_0000);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    step();

    // Back-to-back write then read of the same word with no wait states.
    hsel0 = 1'b1;
    addr_ph(1'b1, 3'b010, 32'h0010);
    step();
    hwdata = 32'hDEAD_BEEF;
    addr_ph(1'b0, 3'b010, 32'h0010);
    @(negedge clk);
    chk("b2b_wr_phase", 32'({rdy0, resp0}), 32'b10);
    step();
    htrans = 2'b00;
    @(negedge clk);
    chk("b2b_rd_phase", 32'({rdy0, resp0}), 32'b10);
    chk("b2b_rd_data", rdata0, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("idle_rdata", rdata0, 32'h0);

    // Byte lanes then an overlapping halfword.
    xfer0(1'b1, 3'b000, 32'h0020, 32'h0000_0011, rd);
    xfer0(1'b1, 3'b000, 32'h0021, 32'h0000_2200, rd);
    xfer0(1'b1, 3'b000, 32'h0022, 32'h0033_0000, rd);
    xfer0(1'b1, 3'b000, 32'h0023, 32'h4400_0000, rd);
    xfer0(1'b0, 3'b010, 32'h0020, 32'h0, rd);
    chk("bytes_rd", rd, 32'h4433_2211);
    xfer0(1'b1, 3'b001, 32'h0022, 32'hAABB_0000, rd);
    xfer0(1'b0, 3'b010, 32'h0020, 32'h0, rd);
    chk("half_rd", rd, 32'hAABB_2211);
    xfer0(1'b0, 3'b000, 32'h0021, 32'h0, rd);
    chk("byte_rd_full_word", rd, 32'hAABB_2211);

    // Error responses leave memory untouched (0x400 would alias word 0).
    xfer0(1'b1, 3'b010, 32'h0000, 32'h1234_5678, rd);
    err0("err_misalign", 3'b010, 32'h0002);
    xfer0(1'b0, 3'b010, 32'h0000, 32'h0, rd);
    chk("err_misalign_mem", rd, 32'h1234_5678);
    err0("err_size", 3'b011, 32'h0000);
    xfer0(1'b0, 3'b010, 32'h0000, 32'h0, rd);
    chk("err_size_mem", rd, 32'h1234_5678);
    err0("err_range", 3'b010, 32'h0400);
    xfer0(1'b0, 3'b010, 32'h0000, 32'h0, rd);
    chk("err_range_mem", rd, 32'h1234_5678);
    err0("err_half_odd", 3'b001, 32'h0021);

    // Transfers that must be ignored.
    noop0("noop_idle", 1'b1, 2'b00);
    noop0("noop_busy", 1'b1, 2'b01);
    noop0("noop_unsel", 1'b0, 2'b10);
    xfer0(1'b0, 3'b010, 32'h0000, 32'h0, rd);
    chk("noop_mem", rd, 32'h1234_5678);
    hsel0 = 1'b0;

    // Three wait states.
    xfer3(1'b1, 32'h0030, 32'hCAFE_F00D, rd);
    xfer3(1'b1, 32'h0034, 32'h0BAD_CAFE, rd);
    hsel3 = 1'b1;
    addr_ph(1'b0, 3'b010, 32'h0030);
    step();
    addr_ph(1'b0, 3'b010, 32'h0034);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws3_rd1_wait", 32'({rdy3, resp3}), 32'b00);
    end
    @(negedge clk);
    chk("ws3_rd1_ready", 32'({rdy3, resp3}), 32'b10);
    chk("ws3_rd1_data", rdata3, 32'hCAFE_F00D);
    step();
    htrans = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ws3_rd2_wait", 32'({rdy3, rdata3 != 0}), 32'b00);
    end
    @(negedge clk);
    chk("ws3_rd2_ready", 32'(rdy3), 32'd1);
    chk("ws3_rd2_data", rdata3, 32'h0BAD_CAFE);
    step();

    // Reset during the second wait cycle of a write drops it.
    addr_ph(1'b1, 3'b010, 32'h0030);
    step();
    htrans = 2'b00;
    hwdata = 32'h5555_5555;
    @(negedge clk);
    chk("rst_mid_wait1", 32'(rdy3), 32'd0);
    step();
    #2;
    rst3_n = 1'b0;
    #1;
    chk("rst_mid_outs", {rdy3, resp3, 30'd0} | 32'(rdata3 != 0), 32'h8000_0000);
    @(negedge clk);
    rst3_n = 1'b1;
    xfer3(1'b0, 32'h0030, 32'h0, rd);
    chk("rst_mid_mem", rd, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
